// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - size encodings (same on the request and memory sides)
//   - FSM state type
//   - beats_for_size(): number of byte beats used when an access is split
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    SPLIT  = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_t;

  function automatic logic [2:0] beats_for_size(input logic [1:0] sz);
    case (sz)
      SZ_WORD: beats_for_size = 3'd4;
      SZ_HALF: beats_for_size = 3'd2;
      default: beats_for_size = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational sign/zero extension of raw load data.
//   size_i   : access size (SZ_WORD/SZ_HALF/SZ_BYTE)
//   signed_i : 1 = sign-extend, 0 = zero-extend
//   raw_i    : LSB-aligned raw data
//   res_o    : extended 32-bit result
module load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] raw_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = raw_i;
    case (size_i)
      SZ_HALF: res_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      SZ_BYTE: res_o = {{24{signed_i & raw_i[7]}},  raw_i[7:0]};
      default: res_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator. Takes one load/store at a time,
// drives the byte-addressable memory port, returns a one-cycle response.
//   req_*  : request from the pipeline (accepted on req_valid & req_ready)
//   resp_* : one-cycle completion pulse, extended load data, error flag
//   mem_*  : memory data port (strobes, size, address, write data, read data)
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (response with resp_err) instead of splitting them into byte beats.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              misaligned;
  logic [31:0]       ext_data;

`ifndef MISALIGN_TRAP_EN
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        beat_nxt;
  logic [2:0]        last_beat;

  assign beat_nxt  = beat_q + 2'd1;
  assign last_beat = beats_for_size(size_q) - 3'd1;
`endif

  assign misaligned = ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == SZ_HALF) && req_addr[0]);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
`ifndef MISALIGN_TRAP_EN
    wdata_d     = wdata_q;
    beat_d      = beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          asm_d    = 32'h0;
`ifndef MISALIGN_TRAP_EN
          wdata_d  = req_wdata;
`endif
          if (req_size == SZ_ILL) begin
            state_d = ERR;
          end else if (!misaligned) begin
            state_d     = ACCESS;
            mem_addr_d  = req_addr;
            mem_size_d  = req_size;
            mem_wdata_d = req_wdata;
          end else begin
`ifdef MISALIGN_TRAP_EN
            state_d = ERR;
`else
            // first byte beat is set up here so the port is valid on entry
            state_d     = SPLIT;
            beat_d      = 2'd0;
            mem_addr_d  = req_addr;
            mem_size_d  = SZ_BYTE;
            mem_wdata_d = {24'h0, req_wdata[7:0]};
`endif
          end
        end
      end
      ACCESS: begin
        if (!write_q) asm_d = mem_rdata;
        state_d = RESP;
      end
`ifndef MISALIGN_TRAP_EN
      SPLIT: begin
        if (!write_q) asm_d[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
        if ({1'b0, beat_q} == last_beat) begin
          state_d = RESP;
        end else begin
          beat_d      = beat_nxt;
          mem_addr_d  = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          mem_wdata_d = {24'h0, wdata_q[{beat_nxt, 3'b000} +: 8]};
        end
      end
`endif
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_WORD;
      signed_q    <= 1'b0;
      asm_q       <= 32'h0;
      mem_addr_q  <= '0;
      mem_size_q  <= SZ_WORD;
      mem_wdata_q <= 32'h0;
`ifndef MISALIGN_TRAP_EN
      wdata_q     <= 32'h0;
      beat_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
`ifndef MISALIGN_TRAP_EN
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
`endif
    end
  end

  load_extend u_ext (
    .size_i   (size_q),
    .signed_i (signed_q),
    .raw_i    (asm_q),
    .res_o    (ext_data)
  );

  logic in_access;
  assign in_access = (state_q == ACCESS) || (state_q == SPLIT);

  // strobes are masked by rst so a beat interrupted by reset never commits
  assign mem_read   = in_access & ~write_q & ~rst;
  assign mem_write  = in_access &  write_q & ~rst;
  assign mem_size   = mem_size_q;
  assign mem_signed = 1'b0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP) || (state_q == ERR);
  assign resp_err   = (state_q == ERR);
  assign resp_rdata = ((state_q == RESP) && !write_q) ? ext_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write, mem_signed;
  logic [1:0]  mem_size;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // byte-addressable memory (the environment) and the model's shadow copy
  logic [7:0] mem [256];
  logic [7:0] sh  [256];

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = mem_addr; a1 = mem_addr + 8'd1; a2 = mem_addr + 8'd2; a3 = mem_addr + 8'd3;
    mem_rdata = 32'h0;
    case (mem_size)
      SZ_WORD: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      SZ_HALF: mem_rdata = {16'h0, mem[a1], mem[a0]};
      SZ_BYTE: mem_rdata = {24'h0, mem[a0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_size)
        SZ_WORD: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 8'd1] <= mem_wdata[15:8];
          mem[mem_addr + 8'd2] <= mem_wdata[23:16];
          mem[mem_addr + 8'd3] <= mem_wdata[31:24];
        end
        SZ_HALF: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 8'd1] <= mem_wdata[15:8];
        end
        SZ_BYTE: mem[mem_addr] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    mem[a] = d;
    sh[a]  = d;
  endtask

  // observed results of the last request
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat, nrd, nwr, nboth;
  logic [7:0]  bq_addr[$];
  logic [7:0]  bq_data[$];
  logic [1:0]  bq_size[$];

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [7:0] a, input logic [31:0] wd);
    int g;
    bit to;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // scramble fields: the unit must use its registered copy
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
    bq_addr.delete(); bq_data.delete(); bq_size.delete();
    nrd = 0; nwr = 0; nboth = 0; r_lat = 0; r_rdata = 32'h0; r_err = 1'b0;
    to = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_read && mem_write) nboth++;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) begin
        bq_addr.push_back(mem_addr);
        bq_data.push_back(mem_wdata[7:0]);
        bq_size.push_back(mem_size);
      end
      if (resp_valid) begin
        r_lat = c; r_rdata = resp_rdata; r_err = resp_err; to = 1'b0;
        break;
      end
    end
    if (to) chk("resp_timeout", 32'd1, 32'd0);
  endtask

  // Reference model: operates on whole bytes of the shadow memory.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int nstr);
    int nb;
    bit mis, trap;
    logic [31:0] v;
    nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    mis = (int'(a) % nb) != 0;
`ifdef MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    rd = 32'h0; er = 1'b0;
    if (sz == 2'b11 || (trap && mis)) begin
      er = 1'b1; lat = 1; nstr = 0;
    end else begin
      lat  = mis ? 1 + nb : 2;
      nstr = mis ? nb : 1;
      if (w) begin
        for (int i = 0; i < nb; i++) sh[8'(int'(a) + i)] = 8'(wd >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(sh[8'(int'(a) + i)]) << (8 * i));
        if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    int          elat;
    int          estr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] m_rd;
    logic        m_er;
    int          m_lat, m_str, rv;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      sh[i]  = mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_strobes",    {29'd0, mem_read, mem_write, mem_signed}, 32'd0);
    chk("rst_mem_addr",   32'(mem_addr), 32'd0);
    chk("rst_mem_wdata",  mem_wdata, 32'd0);
    chk("rst_mem_size",   32'(mem_size), 32'd0);
    rst = 1'b0;

    poke(8'h04, 8'h11); poke(8'h05, 8'h00); poke(8'h06, 8'h00); poke(8'h07, 8'h00);
    poke(8'h10, 8'h80);
    poke(8'h21, 8'h34); poke(8'h22, 8'hF2); poke(8'h23, 8'h85);

    tbl[0]  = '{1'b0, 2'b00, 1'b0, 8'h04, 32'h0, 32'h0000_0011, 1'b0, 2, 1};
    tbl[1]  = '{1'b0, 2'b10, 1'b1, 8'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1};
    tbl[2]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0000_0080, 1'b0, 2, 1};
`ifdef MISALIGN_TRAP_EN
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 8'hFE, 32'hA1B2_C3D4, 32'h0, 1'b1, 1, 0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 8'hFE, 32'h0, 32'h0, 1'b1, 1, 0};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 8'h21, 32'h0, 32'h0, 1'b1, 1, 0};
`else
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 8'hFE, 32'hA1B2_C3D4, 32'h0, 1'b0, 5, 4};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 8'hFE, 32'h0, 32'hA1B2_C3D4, 1'b0, 5, 4};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 8'h21, 32'h0, 32'hFFFF_F234, 1'b0, 3, 2};
`endif
    tbl[6]  = '{1'b0, 2'b11, 1'b1, 8'h08, 32'h0, 32'h0, 1'b1, 1, 0};
    tbl[7]  = '{1'b1, 2'b11, 1'b0, 8'h0C, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 8'h22, 32'h0, 32'hFFFF_85F2, 1'b0, 2, 1};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 8'h22, 32'h0, 32'h0000_85F2, 1'b0, 2, 1};
    tbl[10] = '{1'b1, 2'b01, 1'b0, 8'h30, 32'h1234_BEEF, 32'h0, 1'b0, 2, 1};
    tbl[11] = '{1'b0, 2'b01, 1'b0, 8'h30, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1};

    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd);
      model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, m_rd, m_er, m_lat, m_str);
      chk($sformatf("vec%0d_rdata", i), r_rdata, tbl[i].erd);
      chk($sformatf("vec%0d_err", i),   32'(r_err), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_lat", i),   32'(r_lat), 32'(tbl[i].elat));
      chk($sformatf("vec%0d_strobes", i), 32'(nrd + nwr), 32'(tbl[i].estr));
      chk($sformatf("vec%0d_both", i),  32'(nboth), 32'd0);
      if (i == 0 && bq_addr.size() > 0) chk("lw_addr", 32'(bq_addr[0]), 32'h04);
`ifndef MISALIGN_TRAP_EN
      if (i == 3) begin
        chk("sw_split_beats", 32'(bq_addr.size()), 32'd4);
        if (bq_addr.size() == 4) begin
          chk("sw_split_addrs", {bq_addr[0], bq_addr[1], bq_addr[2], bq_addr[3]}, 32'hFEFF_0001);
          chk("sw_split_data",  {bq_data[0], bq_data[1], bq_data[2], bq_data[3]}, 32'hD4C3_B2A1);
          chk("sw_split_size",  32'(bq_size[0]), 32'(SZ_BYTE));
        end
      end
`endif
    end

`ifndef MISALIGN_TRAP_EN
    // reset during beat 2 of a split store
    poke(8'h41, 8'hEE); poke(8'h42, 8'hEE); poke(8'h43, 8'hEE); poke(8'h44, 8'hEE);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 8'h41; req_wdata = 32'h1122_3344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rstmid_beat2_addr", 32'(mem_addr), 32'h43);
    rst = 1'b1;
    #1 chk("rstmid_write_masked", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("rstmid_ready",   32'(req_ready), 32'd1);
    chk("rstmid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;
    rv = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) rv++;
      @(negedge clk);
    end
    chk("rstmid_no_resp", 32'(rv), 32'd0);
    chk("rstmid_bytes", {mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]}, 32'h4433_EEEE);
    sh[8'h41] = 8'h44; sh[8'h42] = 8'h33;
`endif

    // randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [7:0]  a;
      logic [31:0] wd;
      w  = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 8'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_req(w, sz, sg, a, wd);
      model(w, sz, sg, a, wd, m_rd, m_er, m_lat, m_str);
      chk("rnd_rdata", r_rdata, m_rd);
      chk("rnd_err",   32'(r_err), 32'(m_er));
      chk("rnd_lat",   32'(r_lat), 32'(m_lat));
      chk("rnd_strobes", 32'(w ? nwr : nrd), 32'(m_str));
      chk("rnd_wrong_strobe", 32'(w ? nrd : nwr) + 32'(nboth), 32'd0);
    end

    @(negedge clk);
    rv = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== sh[i]) rv++;
    chk("mem_image_diffs", 32'(rv), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute/memory stage and drives the byte-addressable unified memory's data-port controls: read/write strobes, size select, signed flag, address and write data.
- Aligned accesses complete in a single memory beat.
- Misaligned accesses are split into little-endian byte beats. Sign/zero extension of loads is done locally on the assembled data.
- Returns a one-cycle response to the pipeline, which stalls while req_ready is low.

Parameters:
- ADDR_W, 8, memory byte-address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal
- req_signed  in  1  1 = sign-extend load (LB/LH), 0 = zero-extend (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: illegal size, or misaligned with trap build
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_size  out  2  size select to memory, same encoding as req_size
- mem_signed  out  1  always driven 0; extension is done in this unit
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  32  beat write data, LSB-aligned
- mem_rdata  in  32  combinational read data for mem_addr and mem_size

Behaviour:
- Reset values:
  - req_ready = 1.
  - resp_valid, resp_err, mem_read, mem_write, mem_signed = 0.
  - resp_rdata, mem_addr, mem_wdata = 0; mem_size = 00.
  - State = IDLE.
- Handshake:
  - A request is accepted on a clock edge with req_valid & req_ready.
  - req_ready = 1 only in IDLE.
  - All req_* fields are registered at acceptance; later changes are ignored.
- Alignment test:
  - Word is aligned when addr[1:0] = 00.
  - Half is aligned when addr[0] = 0.
  - Byte is always aligned.
- States:
  - IDLE: on accept, go to ERR if size = 11; else ACCESS if aligned; else SPLIT with beat counter = 0.
  - ACCESS: one cycle. mem_read or mem_write = 1, mem_size = req size, mem_addr = req addr, mem_wdata = req wdata. For loads, mem_rdata is captured at the end of the cycle. Go to RESP.
  - SPLIT: beats = 4 (word) or 2 (half). Each beat is one cycle with mem_size = 10 and mem_addr = base + beat (wraps).
    - Loads: byte k is captured into assembly bits [8k+7:8k].
    - Stores: mem_wdata[7:0] = req_wdata[8k+7:8k].
    - After the last beat, go to RESP.
  - RESP: one cycle. resp_valid = 1. All mem strobes are 0. Go to IDLE; req_ready rises in the same cycle.
  - ERR: one cycle. resp_valid = 1, resp_err = 1, resp_rdata = 0, no memory strobe. Go to IDLE.
- Load extension in RESP:
  - Word: rdata as assembled.
  - Half: bits [31:16] = bit 15 if signed, else 0.
  - Byte: bits [31:8] = bit 7 if signed, else 0.
- Latency, accept edge to resp_valid high:
  - aligned = 2 cycles
  - misaligned half = 3 cycles
  - misaligned word = 5 cycles
  - error = 1 cycle
- Store commit: the memory commits on the edge ending each cycle with mem_write = 1.
- Strobes: mem_read and mem_write are never high together. Both are 0 outside ACCESS/SPLIT.
- mem_addr, mem_wdata and mem_size hold their last values when strobes are low.
- Reset mid-operation: the next edge returns to IDLE with reset values. Bytes of a split store already committed stay written. No response is issued.

Optional Feature:
- MISALIGN_TRAP_EN defined: misaligned half/word requests go to ERR instead of SPLIT. No memory access occurs. The SPLIT state and beat counter are compiled out.
- Not defined: misaligned requests are split as described above.

Decomposition:
- Package lsu_pkg holds:
  - size constants SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_ILL = 2'b11
  - state enum IDLE/ACCESS/SPLIT/RESP/ERR
  - function beats_for_size
- Sub-module load_extend: combinational sign/zero extender (size, signed, 32-bit raw → 32-bit result), reused by writeback.

Test Plan:
- LW at addr 0x04, mem_rdata = 0x0000_0011 → one ACCESS cycle with mem_read = 1 and mem_addr = 0x04; resp_valid 2 cycles after accept; resp_rdata = 0x0000_0011.
- LB signed at 0x10, byte 0x80 → resp_rdata = 0xFFFF_FF80. Same request with LBU → 0x0000_0080.
- Misaligned SW 0xA1B2C3D4 at 0xFE (split build) → 4 byte writes at 0xFE, 0xFF, 0x00, 0x01 with data D4, C3, B2, A1; resp at cycle 5; a following LW of the same address reads 0xA1B2C3D4.
- Misaligned LH signed at 0x21, bytes 0x34 @0x21 and 0xF2 @0x22 → resp_rdata = 0xFFFF_F234. With MISALIGN_TRAP_EN → resp_err = 1 after 1 cycle, no strobes.
- req_size = 11 → resp_err = 1, resp_rdata = 0, mem_read = mem_write = 0 throughout.
- rst asserted during beat 2 of a split SW → next cycle req_ready = 1, strobes = 0, no resp_valid; bytes 0–1 written, bytes 2–3 unchanged.
